frame_dump_ctrl: RTL and testbench

FRAME_DUMP_CTRL -- requirements
Module: frame_dump_ctrl

---
 rtl/frame_dump_ctrl.sv | 136 +++++++++++++
 tb/tb_frame_dump_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_dump_ctrl.sv
// frame_dump_ctrl: counts video frames on VGA_VS falling edges and opens a
// dump window that starts at a configured frame index. The window is
// optionally gated by the end of a ROM download and is aborted when a new
// download starts.
module frame_dump_ctrl #(
  parameter int unsigned START_FRAME = 0,
  parameter int unsigned LEN_FRAMES  = 0,
  parameter bit          WAIT_DL     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        VGA_VS,
  input  logic        led,
  output logic [31:0] frame_cnt,
  output logic        dump_on,
  output logic        dump_off,
  output logic        dump_active,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DL,
    S_ARMED,
    S_DUMPING,
    S_DONE
  } state_t;

  localparam logic [31:0] START = START_FRAME;
  localparam logic [31:0] LEN   = LEN_FRAMES;

  state_t      state;
  state_t      state_nx;
  state_t      rearm;
  logic        vs_l;
  logic        led_l;
  logic        vs_fall;
  logic        led_fall;
  logic        led_rise;
  logic [31:0] dump_len;
  logic [31:0] dump_len_nx;
  logic        dump_on_nx;
  logic        dump_off_nx;

  assign vs_fall  = vs_l & ~VGA_VS;
  assign led_fall = led_l & ~led;
  assign led_rise = ~led_l & led;

  // Delayed copies of the sync and download inputs for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_l  <= 1'b1;
      led_l <= 1'b0;
    end else begin
      vs_l  <= VGA_VS;
      led_l <= led;
    end
  end

  // Saturating frame counter, advanced one cycle after each vs_fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (vs_fall && (frame_cnt != '1)) begin
      frame_cnt <= frame_cnt + 32'd1;
    end else begin
      frame_cnt <= frame_cnt;
    end
  end

  // Next-state and pulse decode; an abort (led_rise) outranks every other event.
  always_comb begin
    state_nx    = state;
    dump_len_nx = dump_len;
    dump_on_nx  = 1'b0;
    dump_off_nx = 1'b0;
    rearm       = WAIT_DL ? S_WAIT_DL : S_ARMED;
    case (state)
      S_IDLE: begin
        state_nx = rearm;
      end
      S_WAIT_DL: begin
        if (led_fall) begin
          state_nx = S_ARMED;
        end
      end
      S_ARMED: begin
        if (led_rise) begin
          state_nx = rearm;
        end else if (vs_fall && (frame_cnt >= START)) begin
          state_nx    = S_DUMPING;
          dump_on_nx  = 1'b1;
          dump_len_nx = '0;
        end
      end
      S_DUMPING: begin
        if (led_rise) begin
          state_nx    = rearm;
          dump_off_nx = 1'b1;
        end else if (vs_fall) begin
          dump_len_nx = dump_len + 32'd1;
          if ((LEN != '0) && (dump_len_nx == LEN)) begin
            state_nx    = S_DONE;
            dump_off_nx = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_nx = S_DONE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State register and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dump_len    <= '0;
      dump_on     <= 1'b0;
      dump_off    <= 1'b0;
      dump_active <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      dump_len    <= dump_len_nx;
      dump_on     <= dump_on_nx;
      dump_off    <= dump_off_nx;
      dump_active <= (state_nx == S_DUMPING);
      done        <= (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Bench for frame_dump_ctrl: two instances with different parameter sets
// share one stimulus stream and are checked every cycle against an
// event-level reference model, plus directed literal expectations.
module tb_frame_dump_ctrl;

  logic        clk;
  logic        rst_n;
  logic        VGA_VS;
  logic        led;

  logic [31:0] frame_cnt_a, frame_cnt_b;
  logic        dump_on_a, dump_off_a, dump_active_a, done_a;
  logic        dump_on_b, dump_off_b, dump_active_b, done_b;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          cmp_en = 1'b0;
  bit          force_on = 1'b0;

  int unsigned on_cnt_a = 0, off_cnt_a = 0, on_cnt_b = 0, off_cnt_b = 0;
  logic [31:0] on_at_a = '0, on_at_b = '0;

  // A: download-gated, unbounded dump from frame 2.
  frame_dump_ctrl #(.START_FRAME(2), .LEN_FRAMES(0), .WAIT_DL(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .VGA_VS(VGA_VS), .led(led),
    .frame_cnt(frame_cnt_a), .dump_on(dump_on_a), .dump_off(dump_off_a),
    .dump_active(dump_active_a), .done(done_a)
  );

  // B: ungated, two-frame dump from frame 3.
  frame_dump_ctrl #(.START_FRAME(3), .LEN_FRAMES(2), .WAIT_DL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .VGA_VS(VGA_VS), .led(led),
    .frame_cnt(frame_cnt_b), .dump_on(dump_on_b), .dump_off(dump_off_b),
    .dump_active(dump_active_b), .done(done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_WAIT, M_ARMED, M_DUMP, M_DONE} ph_t;
  typedef struct {
    logic [31:0] frames;
    bit          pv;
    bit          pl;
    ph_t         ph;
    int unsigned dumped;
    bit          on;
    bit          off;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(input mdl_t m, input bit rn, input bit vs, input bit ld,
                                input int unsigned start, input int unsigned len, input bit wdl);
    mdl_t n;
    bit vf, lf, lr;
    ph_t back;
    n = m;
    if (!rn) begin
      n.frames = '0; n.pv = 1'b1; n.pl = 1'b0; n.ph = M_IDLE;
      n.dumped = 0;  n.on = 1'b0; n.off = 1'b0;
      return n;
    end
    vf = m.pv && !vs;
    lf = m.pl && !ld;
    lr = !m.pl && ld;
    back = wdl ? M_WAIT : M_ARMED;
    n.on = 1'b0;
    n.off = 1'b0;
    if (m.ph == M_IDLE) n.ph = back;
    else if (m.ph == M_WAIT) begin
      if (lf) n.ph = M_ARMED;
    end else if (m.ph == M_ARMED) begin
      if (lr) n.ph = back;
      else if (vf && (m.frames >= start)) begin
        n.ph = M_DUMP; n.on = 1'b1; n.dumped = 0;
      end
    end else if (m.ph == M_DUMP) begin
      if (lr) begin
        n.ph = back; n.off = 1'b1;
      end else if (vf) begin
        n.dumped = m.dumped + 1;
        if (len != 0 && n.dumped == len) begin
          n.ph = M_DONE; n.off = 1'b1;
        end
      end
    end
    if (vf && m.frames != 32'hFFFF_FFFF) n.frames = m.frames + 32'd1;
    n.pv = vs;
    n.pl = ld;
    return n;
  endfunction

  // Advance both models on the same edge the DUTs sample.
  always @(posedge clk) begin
    ma = step(ma, rst_n, VGA_VS, led, 2, 0, 1'b1);
    mb = step(mb, rst_n, VGA_VS, led, 3, 2, 1'b0);
    if (force_on) ma.frames = 32'hFFFF_FFFE;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus pulse bookkeeping.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("a_frame_cnt", frame_cnt_a, ma.frames);
      check("a_dump_on", 32'(dump_on_a), 32'(ma.on));
      check("a_dump_off", 32'(dump_off_a), 32'(ma.off));
      check("a_dump_active", 32'(dump_active_a), 32'(ma.ph == M_DUMP));
      check("a_done", 32'(done_a), 32'(ma.ph == M_DONE));
      check("b_frame_cnt", frame_cnt_b, mb.frames);
      check("b_dump_on", 32'(dump_on_b), 32'(mb.on));
      check("b_dump_off", 32'(dump_off_b), 32'(mb.off));
      check("b_dump_active", 32'(dump_active_b), 32'(mb.ph == M_DUMP));
      check("b_done", 32'(done_b), 32'(mb.ph == M_DONE));
      if (dump_on_a) begin on_cnt_a++; on_at_a = frame_cnt_a; end
      if (dump_off_a) off_cnt_a++;
      if (dump_on_b) begin on_cnt_b++; on_at_b = frame_cnt_b; end
      if (dump_off_b) off_cnt_b++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vs_frame();
    VGA_VS = 1'b1;
    cyc(3);
    VGA_VS = 1'b0;
    cyc(3);
  endtask

  initial begin
    rst_n = 1'b0; VGA_VS = 1'b1; led = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    check("rst_a_frame_cnt", frame_cnt_a, 32'd0);
    check("rst_a_active", 32'(dump_active_a), 32'd0);
    check("rst_b_done", 32'(done_b), 32'd0);

    // download in progress for frames 0-9
    cyc(2);
    led = 1'b1;
    for (int i = 0; i < 3; i++) vs_frame();
    check("b_no_on_before_start", 32'(on_cnt_b), 32'd0);
    check("b_cnt_3", frame_cnt_b, 32'd3);
    for (int i = 0; i < 3; i++) vs_frame();
    check("b_on_once", 32'(on_cnt_b), 32'd1);
    check("b_on_at_cnt4", on_at_b, 32'd4);
    check("b_off_once", 32'(off_cnt_b), 32'd1);
    check("b_done", 32'(done_b), 32'd1);
    check("b_cnt_6", frame_cnt_b, 32'd6);
    for (int i = 0; i < 4; i++) vs_frame();
    check("a_no_on_during_dl", 32'(on_cnt_a), 32'd0);
    check("a_cnt_10", frame_cnt_a, 32'd10);

    // download ends -> late arm, dump at next frame
    led = 1'b0;
    cyc(2);
    check("a_no_on_at_led_fall", 32'(on_cnt_a), 32'd0);
    vs_frame();
    check("a_on_late_arm", 32'(on_cnt_a), 32'd1);
    check("a_on_at_cnt11", on_at_a, 32'd11);
    check("a_active", 32'(dump_active_a), 32'd1);

    // new download 5 frames into the dump
    for (int i = 0; i < 5; i++) vs_frame();
    check("a_still_active", 32'(dump_active_a), 32'd1);
    led = 1'b1;
    cyc(2);
    check("a_abort_off", 32'(off_cnt_a), 32'd1);
    check("a_abort_inactive", 32'(dump_active_a), 32'd0);
    vs_frame();
    check("a_no_restart_waiting", 32'(on_cnt_a), 32'd1);
    led = 1'b0;
    cyc(2);
    vs_frame();
    check("a_restart", 32'(on_cnt_a), 32'd2);

    // reset mid-dump
    VGA_VS = 1'b1;
    cyc(1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check("mid_rst_a_cnt", frame_cnt_a, 32'd0);
    check("mid_rst_a_active", 32'(dump_active_a), 32'd0);
    check("mid_rst_b_done", 32'(done_b), 32'd0);
    cyc(2);
    check("mid_rst_no_off", 32'(off_cnt_a), 32'd1);

    // abort and start coincide while armed at the start frame
    led = 1'b1;
    cyc(2);
    vs_frame();
    vs_frame();
    led = 1'b0;
    cyc(2);
    VGA_VS = 1'b1;
    cyc(3);
    led = 1'b1;
    VGA_VS = 1'b0;
    cyc(3);
    check("coinc_no_on", 32'(on_cnt_a), 32'd2);
    check("coinc_inactive", 32'(dump_active_a), 32'd0);
    check("coinc_cnt", frame_cnt_a, 32'd3);
    vs_frame();
    check("coinc_waiting", 32'(on_cnt_a), 32'd2);
    led = 1'b0;
    cyc(2);
    vs_frame();
    check("coinc_rearm_on", 32'(on_cnt_a), 32'd3);

    // saturation near the top of the counter
    @(negedge clk);
    #1;
    force dut_a.frame_cnt = 32'hFFFF_FFFE;
    force_on = 1'b1;
    @(posedge clk);
    #1;
    release dut_a.frame_cnt;
    force_on = 1'b0;
    check("sat_preload", frame_cnt_a, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) vs_frame();
    check("sat_cnt", frame_cnt_a, 32'hFFFF_FFFF);

    // randomized traffic
    VGA_VS = 1'b1;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) VGA_VS = ~VGA_VS;
      if ($urandom_range(0, 59) == 0) led = ~led;
      rst_n = ($urandom_range(0, 999) != 0);
      cyc(1);
    end
    rst_n = 1'b1;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
